// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
// Receive-side checker for the six lamp outputs of a highway/farm-road
// traffic-light controller. It registers both lamp groups, decodes them into a
// phase code, follows the HG->HY->FG->FY->HG sequence and enforces the dwell
// rules. Conflicts, illegal codes, illegal sequences and timing violations are
// reported and latch the monitor into FAULT until it is cleared.
//
// Ports
//   CK         in   clock, rising edge
//   RN         in   asynchronous active-low reset
//   en         in   monitor enable (0 forces INIT, no error checking)
//   clr_fault  in   leave FAULT back to INIT
//   lamp_hw    in   highway lamps   [2]=R [1]=Y [0]=G
//   lamp_fm    in   farm-road lamps [2]=R [1]=Y [0]=G
//   phase      out  0=INIT 1=HG 2=HY 3=FG 4=FY 7=FAULT
//   dwell      out  cycles spent in the current phase, saturating
//   err_valid  out  one-cycle pulse when an error is detected
//   err_code   out  last error: 1=CONFLICT 2=BADCODE 3=BADSEQ 4=SHORT_GREEN 5=YELLOW_LEN
//   fault      out  sticky error flag
//   cycle_cnt  out  completed FY->HG transitions, wrapping
module traffic_lamp_monitor #(
    parameter int CW         = 8,
    parameter int MIN_GREEN  = 16,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 5,
    parameter int CNTW       = 8
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            en,
    input  logic            clr_fault,
    input  logic [2:0]      lamp_hw,
    input  logic [2:0]      lamp_fm,
    output logic [2:0]      phase,
    output logic [CW-1:0]   dwell,
    output logic            err_valid,
    output logic [2:0]      err_code,
    output logic            fault,
    output logic [CNTW-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        PH_INIT  = 3'd0,
        PH_HG    = 3'd1,
        PH_HY    = 3'd2,
        PH_FG    = 3'd3,
        PH_FY    = 3'd4,
        PH_FAULT = 3'd7
    } phase_e;

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_CONFLICT = 3'd1;
    localparam logic [2:0] E_BADCODE  = 3'd2;
    localparam logic [2:0] E_BADSEQ   = 3'd3;
    localparam logic [2:0] E_SHORT_G  = 3'd4;
    localparam logic [2:0] E_YEL_LEN  = 3'd5;

    localparam logic [CW-1:0] MIN_G   = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MIN_Y   = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] MAX_Y   = CW'(MAX_YELLOW);
    localparam logic [CW-1:0] DW_ONE  = CW'(1);
    localparam logic [CW-1:0] DW_SAT  = {CW{1'b1}};

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    logic [2:0]      lamp_hw_q, lamp_fm_q;
    phase_e          phase_q, phase_d;
    logic [CW-1:0]   dwell_q, dwell_d;
    logic            err_valid_q, err_valid_d;
    logic [2:0]      err_code_q, err_code_d;
    logic            fault_q, fault_d;
    logic [CNTW-1:0] cycle_cnt_q, cycle_cnt_d;
    // Set while in the first green after INIT; that phase is exempt from the
    // minimum-green rule because we may have joined it part-way through.
    logic            first_q, first_d;

    logic            hw_ok, fm_ok;
    logic            is_conflict, is_badcode;
    logic            code_vld;
    phase_e          code_ph;
    phase_e          next_ph;
    logic            cur_green, cur_yellow;
    logic [CW-1:0]   dwell_inc;
    logic [2:0]      err;

    // Lamp decode works on the registered copy only.
    always_comb begin
        hw_ok       = (lamp_hw_q == L_R) || (lamp_hw_q == L_Y) || (lamp_hw_q == L_G);
        fm_ok       = (lamp_fm_q == L_R) || (lamp_fm_q == L_Y) || (lamp_fm_q == L_G);
        is_conflict = hw_ok && fm_ok && !lamp_hw_q[2] && !lamp_fm_q[2];
        is_badcode  = !hw_ok || !fm_ok;

        code_vld = 1'b1;
        code_ph  = PH_INIT;
        case ({lamp_hw_q, lamp_fm_q})
            {L_G, L_R}: code_ph = PH_HG;
            {L_Y, L_R}: code_ph = PH_HY;
            {L_R, L_G}: code_ph = PH_FG;
            {L_R, L_Y}: code_ph = PH_FY;
            default:    code_vld = 1'b0;   // all-red (or already flagged above)
        endcase
    end

    always_comb begin
        next_ph = PH_INIT;
        case (phase_q)
            PH_HG:   next_ph = PH_HY;
            PH_HY:   next_ph = PH_FG;
            PH_FG:   next_ph = PH_FY;
            PH_FY:   next_ph = PH_HG;
            default: next_ph = PH_INIT;
        endcase
        cur_green  = (phase_q == PH_HG) || (phase_q == PH_FG);
        cur_yellow = (phase_q == PH_HY) || (phase_q == PH_FY);
        dwell_inc  = (dwell_q == DW_SAT) ? dwell_q : dwell_q + DW_ONE;
    end

    always_comb begin
        phase_d     = phase_q;
        dwell_d     = dwell_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        fault_d     = fault_q;
        cycle_cnt_d = cycle_cnt_q;
        first_d     = first_q;
        err         = E_NONE;

        if (!en) begin
            phase_d = PH_INIT;
            dwell_d = '0;
            first_d = 1'b0;
        end else if (phase_q == PH_FAULT) begin
            if (clr_fault) begin
                phase_d = PH_INIT;
                fault_d = 1'b0;
            end
        end else begin
            if (is_conflict) begin
                err = E_CONFLICT;
            end else if (is_badcode) begin
                err = E_BADCODE;
            end else if (!code_vld) begin
                err = E_BADSEQ;
            end else if (phase_q == PH_INIT) begin
                // Only a green is a safe place to start tracking.
                if (code_ph == PH_HG || code_ph == PH_FG) begin
                    phase_d = code_ph;
                    dwell_d = DW_ONE;
                    first_d = 1'b1;
                end
            end else if (code_ph == phase_q) begin
                dwell_d = dwell_inc;
                // Overlong yellow is caught on the edge dwell would pass MAX.
                if (cur_yellow && dwell_q >= MAX_Y)
                    err = E_YEL_LEN;
            end else if (code_ph == next_ph) begin
                if (cur_green && !first_q && dwell_q < MIN_G) begin
                    err = E_SHORT_G;
                end else if (cur_yellow && dwell_q < MIN_Y) begin
                    err = E_YEL_LEN;
                end else begin
                    phase_d = code_ph;
                    dwell_d = DW_ONE;
                    first_d = 1'b0;
                    if (phase_q == PH_FY)
                        cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end else begin
                err = E_BADSEQ;
            end

            if (err != E_NONE) begin
                phase_d     = PH_FAULT;
                dwell_d     = '0;
                err_valid_d = 1'b1;
                err_code_d  = err;
                fault_d     = 1'b1;
                first_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            lamp_hw_q   <= '0;
            lamp_fm_q   <= '0;
            phase_q     <= PH_INIT;
            dwell_q     <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            fault_q     <= 1'b0;
            cycle_cnt_q <= '0;
            first_q     <= 1'b0;
        end else begin
            lamp_hw_q   <= lamp_hw;
            lamp_fm_q   <= lamp_fm;
            phase_q     <= phase_d;
            dwell_q     <= dwell_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            fault_q     <= fault_d;
            cycle_cnt_q <= cycle_cnt_d;
            first_q     <= first_d;
        end
    end

    assign phase     = phase_q;
    assign dwell     = dwell_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign fault     = fault_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor: a table of {inputs, hold cycles,
// expected outputs} rows applied in order, plus hand-written sequences for
// asynchronous reset, dwell saturation and the all-red case.
// Note on timing: the FSM acts on lamps registered one edge earlier, so after
// a row completes, the FSM has consumed the previous row's last sample plus
// all but the last sample of this row.
module tb_traffic_lamp_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       en = 1'b0;
    logic       clr_fault = 1'b0;
    logic [2:0] lamp_hw = G;
    logic [2:0] lamp_fm = R;
    logic [2:0] phase;
    logic [7:0] dwell;
    logic       err_valid;
    logic [2:0] err_code;
    logic       fault;
    logic [7:0] cycle_cnt;

    int checks   = 0;
    int failures = 0;
    int err_hi   = 0;   // total cycles err_valid was seen high

    traffic_lamp_monitor dut (
        .CK        (CK),
        .RN        (RN),
        .en        (en),
        .clr_fault (clr_fault),
        .lamp_hw   (lamp_hw),
        .lamp_fm   (lamp_fm),
        .phase     (phase),
        .dwell     (dwell),
        .err_valid (err_valid),
        .err_code  (err_code),
        .fault     (fault),
        .cycle_cnt (cycle_cnt)
    );

    always #5 CK = ~CK;

    always @(negedge CK) if (err_valid === 1'b1) err_hi++;

    typedef struct {
        logic       en;
        logic       clr;
        logic [2:0] hw;
        logic [2:0] fm;
        int         n;
        int         ph;
        int         dw;     // -1: not checked
        int         code;
        int         flt;
        int         cnt;
        int         errs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic e, logic c, logic [2:0] h, logic [2:0] f, int n,
                                int ph, int dw, int code, int flt, int cnt, int errs);
        vec_t v;
        v.en = e; v.clr = c; v.hw = h; v.fm = f; v.n = n;
        v.ph = ph; v.dw = dw; v.code = code; v.flt = flt; v.cnt = cnt; v.errs = errs;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Hold inputs for n rising edges; returns 1 time unit after a falling edge.
    task automatic step(input logic e, input logic c, input logic [2:0] h,
                        input logic [2:0] f, input int n);
        for (int k = 0; k < n; k++) begin
            en = e; clr_fault = c; lamp_hw = h; lamp_fm = f;
            @(posedge CK);
            @(negedge CK);
        end
        #1;
    endtask

    initial begin
        //            en clr hw fm   n   ph dw  code flt cnt errs
        tbl.push_back(mk(0,0, G,R,  2,  0, 0,  0,0,0,0));  // prefill lamp regs
        tbl.push_back(mk(1,0, G,R, 20,  1,20,  0,0,0,0));
        tbl.push_back(mk(1,0, Y,R,  4,  2, 3,  0,0,0,0));
        tbl.push_back(mk(1,0, R,G, 20,  3,19,  0,0,0,0));
        tbl.push_back(mk(1,0, R,Y,  4,  4, 3,  0,0,0,0));
        tbl.push_back(mk(1,0, G,R, 10,  1, 9,  0,0,1,0));  // FY->HG counted
        tbl.push_back(mk(1,0, Y,R,  1,  1,10,  0,0,1,0));
        tbl.push_back(mk(1,0, Y,R,  1,  7, 0,  4,1,1,1));  // short green
        tbl.push_back(mk(1,0, Y,R,  3,  7, 0,  4,1,1,1));  // FAULT ignores lamps
        tbl.push_back(mk(1,1, G,R,  1,  0, 0,  4,0,1,1));  // clear, code held
        tbl.push_back(mk(1,0, G,R,  2,  1, 2,  4,0,1,1));
        tbl.push_back(mk(1,0, G,G,  1,  1, 3,  4,0,1,1));
        tbl.push_back(mk(1,0, G,R,  1,  7, 0,  1,1,1,2));  // conflict
        tbl.push_back(mk(1,1, G,R,  1,  0, 0,  1,0,1,2));
        tbl.push_back(mk(1,0, G,R,  1,  1, 1,  1,0,1,2));
        tbl.push_back(mk(1,0, 3'b011,R, 1, 1, 2, 1,0,1,2));
        tbl.push_back(mk(1,0, G,R,  1,  7, 0,  2,1,1,3));  // bad code
        tbl.push_back(mk(1,1, G,R,  1,  0, 0,  2,0,1,3));
        tbl.push_back(mk(1,0, G,R, 20,  1,20,  2,0,1,3));
        tbl.push_back(mk(1,0, Y,R,  5,  2, 4,  2,0,1,3));
        tbl.push_back(mk(1,0, Y,R,  1,  2, 5,  2,0,1,3));
        tbl.push_back(mk(1,0, Y,R,  1,  7, 0,  5,1,1,4));  // yellow too long
        tbl.push_back(mk(1,1, G,R,  1,  0, 0,  5,0,1,4));
        tbl.push_back(mk(1,0, G,R,  3,  1, 3,  5,0,1,4));
        tbl.push_back(mk(1,0, Y,R,  2,  2, 1,  5,0,1,4));  // first green exempt
        tbl.push_back(mk(1,0, R,G,  1,  2, 2,  5,0,1,4));
        tbl.push_back(mk(1,0, R,G,  1,  7, 0,  5,1,1,5));  // yellow too short
        tbl.push_back(mk(1,1, G,R,  1,  0, 0,  5,0,1,5));
        tbl.push_back(mk(1,0, G,R,  2,  1, 2,  5,0,1,5));
        tbl.push_back(mk(1,0, R,G,  1,  1, 3,  5,0,1,5));
        tbl.push_back(mk(1,0, R,G,  1,  7, 0,  3,1,1,6));  // HG->FG bad seq
        tbl.push_back(mk(1,1, R,G,  1,  0, 0,  3,0,1,6));
        tbl.push_back(mk(1,0, R,G,  3,  3, 3,  3,0,1,6));
        tbl.push_back(mk(0,0, R,G,  1,  0, 0,  3,0,1,6));  // en=0 forces INIT
        tbl.push_back(mk(1,0, R,G,  2,  3, 2,  3,0,1,6));

        // Reset state, held from time 0.
        #1;
        chk("reset phase", phase, 0);
        chk("reset dwell", dwell, 0);
        chk("reset err_valid", err_valid, 0);
        chk("reset err_code", err_code, 0);
        chk("reset fault", fault, 0);
        chk("reset cycle_cnt", cycle_cnt, 0);
        @(negedge CK);
        RN = 1'b1;
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].hw, tbl[i].fm, tbl[i].n);
            chk($sformatf("row%0d phase", i), phase, tbl[i].ph);
            if (tbl[i].dw >= 0) chk($sformatf("row%0d dwell", i), dwell, tbl[i].dw);
            chk($sformatf("row%0d err_code", i), err_code, tbl[i].code);
            chk($sformatf("row%0d fault", i), fault, tbl[i].flt);
            chk($sformatf("row%0d cycle_cnt", i), cycle_cnt, tbl[i].cnt);
            chk($sformatf("row%0d err_pulses", i), err_hi, tbl[i].errs);
        end

        // Asynchronous reset in the middle of FG: no clock edge involved.
        #2;
        RN = 1'b0;
        #1;
        chk("async phase", phase, 0);
        chk("async dwell", dwell, 0);
        chk("async err_code", err_code, 0);
        chk("async fault", fault, 0);
        chk("async cycle_cnt", cycle_cnt, 0);
        chk("async err_valid", err_valid, 0);
        @(negedge CK);
        RN = 1'b1;
        #1;

        // Dwell saturates at 255 during a long green.
        step(0, 0, G, R, 2);
        step(1, 0, G, R, 300);
        chk("sat phase", phase, 1);
        chk("sat dwell", dwell, 255);
        chk("sat err_pulses", err_hi, 6);

        // All-red is an illegal sequence.
        step(1, 0, R, R, 2);
        chk("allred phase", phase, 7);
        chk("allred err_code", err_code, 3);
        chk("allred fault", fault, 1);
        chk("allred err_pulses", err_hi, 7);
        chk("allred cycle_cnt", cycle_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
